// File: rtl/bsg_link_downstream_gearbox_if.sv
// Link-side and core-side signals of the downstream gearbox, grouped so the
// gearbox and its driver connect through one port.
interface bsg_link_downstream_gearbox_if #(
    parameter int IO_W   = 8,
    parameter int CORE_W = 32
);
    logic              io_valid_in;
    logic [IO_W-1:0]   io_data_in;
    logic              io_token_out;
    logic              core_valid_out;
    logic [CORE_W-1:0] core_data_out;
    logic              core_ready;
    logic              overflow_o;

    modport master (
        output io_valid_in, io_data_in, core_ready,
        input  io_token_out, core_valid_out, core_data_out, overflow_o
    );

    modport slave (
        input  io_valid_in, io_data_in, core_ready,
        output io_token_out, core_valid_out, core_data_out, overflow_o
    );
endinterface

// File: rtl/bsg_link_downstream_gearbox.sv
// Buffers IO_W beats from the link, assembles CORE_W words for the core and returns
// one credit per 2^LG_TOKEN_DECIM entries consumed. BSG_LINK_DS_OVERFLOW_DETECT_EN enables the sticky overflow flag.
module bsg_link_downstream_gearbox #(
    parameter int IO_W           = 8,
    parameter int CORE_W         = 32,
    parameter int DEPTH          = 64,
    parameter int LG_TOKEN_DECIM = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    bsg_link_downstream_gearbox_if.slave link
);
    localparam int RATIO = CORE_W / IO_W;
    localparam int LG_D  = $clog2(DEPTH);

    typedef logic [LG_D:0] ptr_t;
    localparam ptr_t RATIO_P = ptr_t'(RATIO);

    logic [IO_W-1:0]            mem_q [DEPTH];
    ptr_t                       wptr_q, wptr_d, rptr_q, rptr_d, occ, rptr_adv;
    logic                       io_valid_q;
    logic [IO_W-1:0]            io_data_q;
    logic                       core_valid_q, core_valid_d;
    logic [CORE_W-1:0]          core_data_q, core_data_d;
    logic                       token_q, token_d;
    logic                       full, wr_en, load;
    logic [RATIO-1:0][IO_W-1:0] lanes;

    assign occ      = wptr_q - rptr_q;
    assign full     = (wptr_q[LG_D] != rptr_q[LG_D]) && (wptr_q[LG_D-1:0] == rptr_q[LG_D-1:0]);
    assign wr_en    = io_valid_q && !full;
    assign load     = (occ >= RATIO_P) && (!core_valid_q || link.core_ready);
    assign rptr_adv = rptr_q + RATIO_P;

    // Oldest entry lands in lane 0, i.e. the word's LSBs.
    for (genvar l = 0; l < RATIO; l++) begin : g_lane
        logic [LG_D-1:0] ra;
        assign ra       = rptr_q[LG_D-1:0] + LG_D'(l);
        assign lanes[l] = mem_q[ra];
    end

    always_comb begin
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        core_valid_d = core_valid_q;
        core_data_d  = core_data_q;
        token_d      = 1'b0;
        if (wr_en) wptr_d = wptr_q + ptr_t'(1);
        if (load) begin
            rptr_d       = rptr_adv;
            core_valid_d = 1'b1;
            core_data_d  = lanes;
            // The decimation bit flips once per 2^LG_TOKEN_DECIM entries read.
            token_d      = rptr_q[LG_TOKEN_DECIM] ^ rptr_adv[LG_TOKEN_DECIM];
        end else if (core_valid_q && link.core_ready) begin
            core_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wptr_q[LG_D-1:0]] <= io_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            io_valid_q   <= 1'b0;
            io_data_q    <= '0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            core_valid_q <= 1'b0;
            core_data_q  <= '0;
            token_q      <= 1'b0;
        end else begin
            io_valid_q   <= link.io_valid_in;
            io_data_q    <= link.io_data_in;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            core_valid_q <= core_valid_d;
            core_data_q  <= core_data_d;
            token_q      <= token_d;
        end
    end

`ifdef BSG_LINK_DS_OVERFLOW_DETECT_EN
    logic overflow_q;
    always_ff @(posedge clk) begin
        if (rst)                     overflow_q <= 1'b0;
        else if (io_valid_q && full) overflow_q <= 1'b1;
    end
    assign link.overflow_o = overflow_q;
`else
    assign link.overflow_o = 1'b0;
`endif

    assign link.io_token_out   = token_q;
    assign link.core_valid_out = core_valid_q;
    assign link.core_data_out  = core_data_q;
endmodule
